fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer for the 9-bit instruction ROM.
- Drives the ROM address, qualifies the returned word for the decoder, and redirects the PC on taken branches.
- Freezes on stall, detects the halt word, and reports run status plus cycle and retired-instruction counts to the test harness.
- Sits between the top-level start/done handshake and the ROM/decoder. The ROM is combinational: a word is valid in the same cycle as its address.

Parameters:
- START_PC, 16'd0, PC loaded on reset and on each accepted start.
- ROM_DEPTH, 16'd256, number of valid ROM addresses. A PC at or above this value is a fault.
- HALT_WORD, 9'b0_1111_1111, instruction encoding that ends the program.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- stall  in  1  execute-stage hold; freezes PC and instruction count.
- branch_taken  in  1  execute redirect request, sampled only in RUN.
- branch_target  in  16  absolute next PC when branch_taken is accepted.
- instr_in  in  9  ROM word at pc_out (format, opcode, sign, operand / immediate).
- pc_out  out  16  ROM address.
- instr_valid  out  1  instr_in is to be executed this cycle.
- running  out  1  state == RUN.
- done  out  1  level; high in DONE until the next start.
- fault  out  1  run ended by an out-of-range PC; cleared on start.
- cycle_count  out  16  cycles spent in RUN, saturating.
- instr_count  out  16  retired instructions (instr_valid cycles), saturating.

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset values: state=IDLE, pc_out=START_PC, done=0, fault=0, cycle_count=0, instr_count=0. Combinational outputs follow: instr_valid=0, running=0.
- IDLE: pc held at START_PC. start -> RUN; counters cleared on the same edge.
- DONE: pc, counters, done and fault held. start -> RUN, pc=START_PC, counters cleared, done=0, fault=0.
- RUN: instr_valid = !stall && pc_out < ROM_DEPTH && instr_in != HALT_WORD. Combinational, zero latency.
- RUN next-PC and next-state priority, highest first:
  1. pc_out >= ROM_DEPTH -> DONE, fault=1, pc held.
  2. stall -> pc held; branch_taken is ignored, and execute must hold it until stall drops.
  3. instr_in == HALT_WORD -> DONE, pc held on the halt address; the halt is not counted as retired.
  4. branch_taken -> pc=branch_target.
  5. Otherwise pc=pc+1, 16-bit wrap (16'hFFFF -> 0; only reachable when ROM_DEPTH = 65536).
- A branch target at or beyond ROM_DEPTH is accepted; the fault fires on the following cycle.
- start while in RUN is ignored.
- cycle_count: +1 every RUN cycle, including stall, halt and fault cycles. Saturates at 16'hFFFF.
- instr_count: +1 on each instr_valid cycle. Saturates at 16'hFFFF.
- done and fault are registered and asserted the cycle after the halt or fault edge.
- Reset mid-run returns to IDLE at once. No partial state survives.

Decomposition:
- Shared include `isa_defs`:
  - state encodings S_IDLE, S_RUN, S_DONE
  - HALT_WORD default
  - field slice positions: format [8], opcode [7:4], sign [3], operand [2:0], immediate [7:0]
- Sub-module `sat_counter` (WIDTH parameter; inputs clear and inc; saturating), instantiated twice for cycle_count and instr_count.
- Next-PC mux and FSM stay inline in fetch_sequencer.

Test Plan:
1. Reset then start. ROM words 0..3 plain, word 4 = HALT_WORD. Expect:
   - pc_out 0,1,2,3,4, then hold at 4
   - done high the cycle after pc=4
   - instr_count=4, cycle_count=5
2. stall high for 3 cycles at pc=2, with branch_taken=1 and branch_target=20 asserted during the stall and held one cycle past it. Expect:
   - pc holds at 2 for 3 cycles, instr_valid=0 throughout
   - branch is ignored until stall drops, then pc=20
   - instr_count is unchanged during the stall
3. branch_taken=1 with branch_target=16'd300 while ROM_DEPTH=256. Expect:
   - pc=300
   - next cycle: instr_valid=0, then DONE with fault=1 and pc held at 300
4. Assert reset asynchronously mid-cycle at pc=7 while running. Expect:
   - pc_out=0, running=0, counters=0 before the next clk edge
   - a subsequent start restarts from 0
5. From DONE, pulse start. Expect:
   - pc=START_PC, done=0, fault=0, counters cleared, running=1
   - start pulses while running have no effect
6. Preload instr_count to 16'hFFFE via a long straight-line program. Expect it to saturate at 16'hFFFF and not wrap.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA definitions for the fetch sequencer: FSM state encodings,
// halt encoding and instruction field positions.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] HALT_WORD_DEFAULT = 9'b0_1111_1111;

    // Instruction word layout: format | opcode | sign | operand, or format | immediate
    localparam int FORMAT_BIT  = 8;
    localparam int OPCODE_MSB  = 7;
    localparam int OPCODE_LSB  = 4;
    localparam int SIGN_BIT    = 3;
    localparam int OPERAND_MSB = 2;
    localparam int OPERAND_LSB = 0;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;

    function automatic logic is_halt(input logic [8:0] word, input logic [8:0] halt_word);
        return word == halt_word;
    endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the 9-bit instruction ROM: drives the ROM
// address, qualifies words for the decoder, follows branches and stops on halt/fault.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] START_PC  = 16'd0,
    parameter logic [16:0] ROM_DEPTH = 17'd256,
    parameter logic [8:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [8:0]  instr_in,
    output logic [15:0] pc_out,
    output logic        instr_valid,
    output logic        running,
    output logic        done,
    output logic        fault,
    output logic [15:0] cycle_count,
    output logic [15:0] instr_count
);

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic        done_reg, done_next;
    logic        fault_reg, fault_next;
    logic        cnt_clear;
    logic        pc_in_range;
    logic        halt_seen;

    // ROM_DEPTH is one bit wider so a full 64K ROM can be expressed
    assign pc_in_range = ({1'b0, pc_reg} < ROM_DEPTH);
    assign halt_seen   = is_halt(instr_in, HALT_WORD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= START_PC;
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            done_reg  <= done_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        done_next  = done_reg;
        fault_next = fault_reg;
        cnt_clear  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                pc_next = START_PC;
                if (start) begin
                    state_next = S_RUN;
                    cnt_clear  = 1'b1;
                end
            end
            S_RUN: begin
                // Fault outranks stall so an out-of-range PC can never hang the run
                if (!pc_in_range) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    fault_next = 1'b1;
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (halt_seen) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else if (branch_taken) begin
                    pc_next = branch_target;
                end else begin
                    pc_next = pc_reg + 16'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    pc_next    = START_PC;
                    done_next  = 1'b0;
                    fault_next = 1'b0;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                pc_next    = START_PC;
            end
        endcase
    end

    assign running     = (state_reg == S_RUN);
    assign instr_valid = running && !stall && pc_in_range && !halt_seen;
    assign pc_out      = pc_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;

    sat_counter #(.WIDTH(16)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (running),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(16)) u_instr_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (instr_valid),
        .count (instr_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_sequencer;

    localparam int         DEPTH    = 256;
    localparam int         START    = 0;
    localparam logic [8:0] HALT     = 9'b0_1111_1111;
    localparam int         SAT      = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;
    logic [8:0]  instr_in;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic        running;
    logic        done;
    logic        fault;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    logic [8:0] rom [0:65535];

    always #5 clk = ~clk;

    assign instr_in = rom[pc_out];

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .running       (running),
        .done          (done),
        .fault         (fault),
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: 0 = idle, 1 = run, 2 = done
    int m_state = 0;
    int m_pc    = START;
    int m_cyc   = 0;
    int m_ins   = 0;
    bit m_done  = 1'b0;
    bit m_fault = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fill_plain();
        logic [8:0] w;
        for (int i = 0; i < 65536; i++) begin
            w = 9'($urandom);
            if (w == HALT) w = 9'h000;
            rom[i] = w;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(0, 39) == 0) rom[i] = HALT;
            else rom[i] = (9'($urandom) == HALT) ? 9'h001 : 9'($urandom);
        end
    endtask

    // One clock: compare at negedge against the model, advance model at posedge.
    // Returns 1 time unit after the posedge so the caller can drive inputs.
    task automatic cycle();
        int n_state, n_pc, n_cyc, n_ins;
        bit n_done, n_fault, halt, valid;
        @(negedge clk);
        if (reset) begin
            m_state = 0; m_pc = START; m_cyc = 0; m_ins = 0; m_done = 0; m_fault = 0;
        end
        halt  = (rom[m_pc] == HALT);
        valid = (m_state == 1) && !stall && (m_pc < DEPTH) && !halt;
        chk("pc_out",      int'(pc_out),      m_pc);
        chk("instr_valid", int'(instr_valid), int'(valid));
        chk("running",     int'(running),     int'(m_state == 1));
        chk("done",        int'(done),        int'(m_done));
        chk("fault",       int'(fault),       int'(m_fault));
        chk("cycle_count", int'(cycle_count), m_cyc);
        chk("instr_count", int'(instr_count), m_ins);
        n_state = m_state; n_pc = m_pc; n_cyc = m_cyc; n_ins = m_ins;
        n_done = m_done; n_fault = m_fault;
        if (!reset) begin
            if (m_state == 1) begin
                n_cyc = (m_cyc < SAT) ? m_cyc + 1 : SAT;
                if (valid) n_ins = (m_ins < SAT) ? m_ins + 1 : SAT;
                if (m_pc >= DEPTH) begin
                    n_state = 2; n_done = 1; n_fault = 1;
                end else if (!stall) begin
                    if (halt) begin
                        n_state = 2; n_done = 1;
                    end else if (branch_taken) begin
                        n_pc = int'(branch_target);
                    end else begin
                        n_pc = (m_pc + 1) % 65536;
                    end
                end
            end else if (start) begin
                n_state = 1; n_pc = START; n_cyc = 0; n_ins = 0; n_done = 0; n_fault = 0;
            end
        end
        @(posedge clk);
        m_state = n_state; m_pc = n_pc; m_cyc = n_cyc; m_ins = n_ins;
        m_done = n_done; m_fault = n_fault;
        #1;
    endtask

    initial begin
        int n;
        fill_plain();
        rom[4] = HALT;

        // Reset state
        cycle();
        cycle();
        chk("reset pc", int'(pc_out), 0);
        chk("reset running", int'(running), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b0;
        cycle();

        // T1: straight run to a halt at address 4
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t1 pc seq", int'(pc_out), k);
            cycle();
        end
        chk("t1 pc hold", int'(pc_out), 4);
        chk("t1 done", int'(done), 1);
        chk("t1 instr_count", int'(instr_count), 4);
        chk("t1 cycle_count", int'(cycle_count), 5);
        cycle();
        chk("t1 pc still", int'(pc_out), 4);
        $display("T1 halt run: pc=%0d done=%0d instr=%0d cycles=%0d", pc_out, done, instr_count, cycle_count);

        // T2: stall at pc=2 with a branch request held across it
        fill_plain();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        chk("t2 pc", int'(pc_out), 2);
        chk("t2 instr_count", int'(instr_count), 2);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'd20;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2 valid in stall", int'(instr_valid), 0);
            cycle();
            chk("t2 pc frozen", int'(pc_out), 2);
            chk("t2 count frozen", int'(instr_count), 2);
        end
        stall = 1'b0;
        cycle();
        chk("t2 branch after stall", int'(pc_out), 20);
        chk("t2 instr_count", int'(instr_count), 3);
        $display("T2 stall+branch: pc=%0d instr=%0d", pc_out, instr_count);

        // T3: branch beyond the ROM faults one cycle later
        branch_target = 16'd300;
        cycle();
        chk("t3 pc", int'(pc_out), 300);
        branch_taken = 1'b0;
        #1;
        chk("t3 valid oor", int'(instr_valid), 0);
        chk("t3 running", int'(running), 1);
        cycle();
        chk("t3 done", int'(done), 1);
        chk("t3 fault", int'(fault), 1);
        chk("t3 pc held", int'(pc_out), 300);
        chk("t3 running off", int'(running), 0);
        cycle();
        chk("t3 pc still", int'(pc_out), 300);
        $display("T3 fault: pc=%0d done=%0d fault=%0d", pc_out, done, fault);

        // T5: restart from DONE, starts while running are ignored
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5 pc", int'(pc_out), 0);
        chk("t5 done", int'(done), 0);
        chk("t5 fault", int'(fault), 0);
        chk("t5 cycle_count", int'(cycle_count), 0);
        chk("t5 instr_count", int'(instr_count), 0);
        chk("t5 running", int'(running), 1);
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t5 start ignored pc", int'(pc_out), 2);
        chk("t5 start ignored cycles", int'(cycle_count), 2);
        $display("T5 restart: pc=%0d cycles=%0d", pc_out, cycle_count);

        // T4: asynchronous reset mid-cycle at pc=7
        n = 0;
        while (pc_out != 16'd7 && n < 20) begin
            cycle();
            n++;
        end
        chk("t4 reached pc7", int'(pc_out), 7);
        #2;
        reset = 1'b1;
        #1;
        chk("t4 async pc", int'(pc_out), 0);
        chk("t4 async running", int'(running), 0);
        chk("t4 async cycles", int'(cycle_count), 0);
        chk("t4 async instrs", int'(instr_count), 0);
        cycle();
        reset = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t4 restart pc", int'(pc_out), 0);
        chk("t4 restart running", int'(running), 1);
        cycle();
        chk("t4 restart pc+1", int'(pc_out), 1);
        $display("T4 async reset: pc=%0d running=%0d", pc_out, running);

        // Randomized traffic
        fill_random();
        for (int k = 0; k < 3000; k++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(256, 400))
                                                         : 16'($urandom_range(0, 255));
            start         = ($urandom_range(0, 7) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; start = 1'b0;
        $display("RANDOM phase: %0d comparisons so far", n_total);

        // T6: instr_count saturation over a looping straight-line program
        fill_plain();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (instr_count != 16'hFFFE && n < 70000) begin
            branch_taken  = (pc_out == 16'd255);
            branch_target = 16'd0;
            cycle();
            n++;
        end
        chk("t6 preload", int'(instr_count), 16'hFFFE);
        for (int k = 0; k < 4; k++) begin
            branch_taken  = (pc_out == 16'd255);
            branch_target = 16'd0;
            cycle();
        end
        chk("t6 saturate instr", int'(instr_count), 16'hFFFF);
        chk("t6 saturate cycles", int'(cycle_count), 16'hFFFF);
        $display("T6 saturation: instr=%0d cycles=%0d", instr_count, cycle_count);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
